// File: rtl/sobel_pkg.sv
// Shared definitions for the Sobel window generator: default geometry,
// controller state encoding and a counter-width helper.
package sobel_pkg;

    localparam int DEF_IMG_COLS = 576;
    localparam int DEF_IMG_ROWS = 436;
    localparam int DEF_PIX_W    = 8;

    typedef enum logic [1:0] {
        ST_FILL = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } sobel_state_e;

    // Bits needed to index 0..n-1, never less than one bit.
    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sobel_line_buf.sv
// One-row line buffer: single clock, one write port and one registered read port.
// Contents are never reset; every location is rewritten before it is used.
module sobel_line_buf
    import sobel_pkg::*;
#(
    parameter int DEPTH = DEF_IMG_COLS,
    parameter int WIDTH = DEF_PIX_W
) (
    input  logic                    clk,
    input  logic                    wr_en,
    input  logic [cnt_w(DEPTH)-1:0] wr_addr,
    input  logic [WIDTH-1:0]        wr_data,
    input  logic [cnt_w(DEPTH)-1:0] rd_addr,
    output logic [WIDTH-1:0]        rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rd_data_q;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data_q <= mem[rd_addr];
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/sobel_window_gen.sv
// Raster-scan 3x3 window generator: emits the top and bottom rows of every
// interior window through a single stallable output register.
module sobel_window_gen
    import sobel_pkg::*;
#(
    parameter int IMG_COLS = DEF_IMG_COLS,
    parameter int IMG_ROWS = DEF_IMG_ROWS,
    parameter int PIX_W    = DEF_PIX_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [PIX_W-1:0] in_data,
    output logic             in_ready,
    output logic [PIX_W-1:0] z1,
    output logic [PIX_W-1:0] z2,
    output logic [PIX_W-1:0] z3,
    output logic [PIX_W-1:0] z4,
    output logic [PIX_W-1:0] z5,
    output logic [PIX_W-1:0] z6,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             frame_done
);

    localparam int COL_W = cnt_w(IMG_COLS);
    localparam int ROW_W = cnt_w(IMG_ROWS);
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(IMG_COLS - 1);
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(IMG_ROWS - 1);

    sobel_state_e state_q, state_d;
    logic [COL_W-1:0] c_q, c_d;
    logic [ROW_W-1:0] r_q, r_d;
    logic [PIX_W-1:0] top1_q, top1_d, top2_q, top2_d;
    logic [PIX_W-1:0] bot1_q, bot1_d, bot2_q, bot2_d;
    logic [PIX_W-1:0] taps_q [6];
    logic [PIX_W-1:0] taps_d [6];
    logic             out_valid_q, out_valid_d;
    logic [PIX_W-1:0] lb_wr [2];
    logic [PIX_W-1:0] lb_rd [2];
    logic             accept;
    logic             emit;
    logic             run_active;

    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;
    assign emit     = accept && run_active && (c_q >= COL_W'(2));

    // Raster position of the next pixel to be accepted.
    always_comb begin
        c_d = c_q;
        r_d = r_q;
        if (accept) begin
            if (c_q == LAST_COL) begin
                c_d = '0;
                r_d = (r_q == LAST_ROW) ? '0 : r_q + ROW_W'(1);
            end else begin
                c_d = c_q + COL_W'(1);
            end
        end
    end

    // Buffer 0 holds row r-1, buffer 1 holds row r-2. Reading at c_d makes the
    // registered read data line up with the pixel accepted at column c_q.
    assign lb_wr[0] = in_data;
    assign lb_wr[1] = lb_rd[0];

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_lb
            sobel_line_buf #(
                .DEPTH (IMG_COLS),
                .WIDTH (PIX_W)
            ) u_lb (
                .clk     (clk),
                .wr_en   (accept),
                .wr_addr (c_q),
                .wr_data (lb_wr[gi]),
                .rd_addr (c_d),
                .rd_data (lb_rd[gi])
            );
        end
    endgenerate

    always_comb begin
        top1_d = top1_q;
        top2_d = top2_q;
        bot1_d = bot1_q;
        bot2_d = bot2_q;
        if (accept) begin
            top1_d = top2_q;
            top2_d = lb_rd[1];
            bot1_d = bot2_q;
            bot2_d = in_data;
        end
    end

    // A held window is never overwritten: emit implies in_ready.
    always_comb begin
        taps_d      = taps_q;
        out_valid_d = out_valid_q;
        if (emit) begin
            taps_d[0]   = top1_q;
            taps_d[1]   = top2_q;
            taps_d[2]   = lb_rd[1];
            taps_d[3]   = bot1_q;
            taps_d[4]   = bot2_q;
            taps_d[5]   = in_data;
            out_valid_d = 1'b1;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_FILL: begin
                if (accept && (r_q == ROW_W'(1)) && (c_q == LAST_COL)) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (accept && (r_q == LAST_ROW) && (c_q == LAST_COL)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_FILL;
            default: state_d = ST_FILL;
        endcase
    end

    always_comb begin
        frame_done = 1'b0;
        run_active = 1'b0;
        case (state_q)
            ST_RUN:  run_active = 1'b1;
            ST_DONE: frame_done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_FILL;
            c_q         <= '0;
            r_q         <= '0;
            top1_q      <= '0;
            top2_q      <= '0;
            bot1_q      <= '0;
            bot2_q      <= '0;
            out_valid_q <= 1'b0;
            for (int i = 0; i < 6; i++) begin
                taps_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            c_q         <= c_d;
            r_q         <= r_d;
            top1_q      <= top1_d;
            top2_q      <= top2_d;
            bot1_q      <= bot1_d;
            bot2_q      <= bot2_d;
            out_valid_q <= out_valid_d;
            for (int i = 0; i < 6; i++) begin
                taps_q[i] <= taps_d[i];
            end
        end
    end

    assign out_valid = out_valid_q;
    assign z1 = taps_q[0];
    assign z2 = taps_q[1];
    assign z3 = taps_q[2];
    assign z4 = taps_q[3];
    assign z5 = taps_q[4];
    assign z6 = taps_q[5];

endmodule

// File: tb/tb_sobel_window_gen.sv
// Scoreboard bench for sobel_window_gen on a 5x4 image: stimulus pushes
// expected windows, a negedge monitor pops and compares each output transfer.
module tb_sobel_window_gen;

    localparam int COLS = 5;
    localparam int ROWS = 4;
    localparam int NPIX = COLS * ROWS;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_ready;
    logic [7:0] z1, z2, z3, z4, z5, z6;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic       frame_done;

    always #5 clk = ~clk;

    sobel_window_gen #(
        .IMG_COLS (COLS),
        .IMG_ROWS (ROWS),
        .PIX_W    (8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .z1         (z1),
        .z2         (z2),
        .z3         (z3),
        .z4         (z4),
        .z5         (z5),
        .z6         (z6),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .frame_done (frame_done)
    );

    int          checks = 0;
    int          passed = 0;
    int          win_seen = 0;
    int          fd_cnt = 0;
    bit          rand_ready = 1'b0;
    logic [47:0] exp_q [$];
    logic [47:0] exp_a [6];
    logic [7:0]  fpix [NPIX];

    task automatic check(input string name, input logic [47:0] act, input logic [47:0] req);
        checks++;
        if (act === req) passed++;
        else $display("FAIL %s: got %h, want %h", name, act, req);
    endtask

    // Monitor: one line per output transfer, compared against the scoreboard.
    initial begin
        logic [47:0] got;
        logic [47:0] w;
        forever begin
            @(negedge clk);
            if (frame_done) fd_cnt++;
            if (reset && out_valid && out_ready) begin
                got = {z1, z2, z3, z4, z5, z6};
                if (exp_q.size() == 0) begin
                    checks++;
                    $display("FAIL unexpected_window: got %h, want none", got);
                end else begin
                    w = exp_q.pop_front();
                    win_seen++;
                    $display("window %0d: z=%h", win_seen, got);
                    check("window", got, w);
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (rand_ready) out_ready = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running, want finish");
        $fatal(1, "watchdog");
    end

    task automatic send_pixel(input logic [7:0] v);
        int n;
        in_valid = 1'b1;
        in_data  = v;
        n = 0;
        forever begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk);
                #1;
                break;
            end
            n++;
            if (n > 300) begin
                checks++;
                $display("FAIL accept_timeout: in_ready=0, want 1");
                @(posedge clk);
                #1;
                break;
            end
        end
    endtask

    task automatic send_frame(input bit gaps);
        for (int i = 0; i < NPIX; i++) begin
            if (gaps && $urandom_range(0, 2) == 0) begin
                in_valid = 1'b0;
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
            send_pixel(fpix[i]);
        end
    endtask

    task automatic fill_pattern(input logic [7:0] base);
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                fpix[r*COLS+c] = base + 8'(16 * r + c);
    endtask

    task automatic push_table(input logic [7:0] off);
        logic [47:0] w;
        for (int i = 0; i < 6; i++) begin
            w = exp_a[i];
            for (int k = 0; k < 6; k++) w[k*8 +: 8] = w[k*8 +: 8] + off;
            exp_q.push_back(w);
        end
    endtask

    // Reference windows straight from the stored frame.
    task automatic push_model();
        for (int y = 1; y <= ROWS - 2; y++)
            for (int x = 1; x <= COLS - 2; x++)
                exp_q.push_back({fpix[(y-1)*COLS+x-1], fpix[(y-1)*COLS+x], fpix[(y-1)*COLS+x+1],
                                 fpix[(y+1)*COLS+x-1], fpix[(y+1)*COLS+x], fpix[(y+1)*COLS+x+1]});
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < 300) begin
            @(posedge clk);
            n++;
        end
        #1;
        check(name, 48'(exp_q.size()), 48'd0);
    endtask

    task automatic stall_ctrl();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid && n < 300);
        check("stall_first_valid", {47'd0, out_valid}, 48'd1);
        repeat (3) begin
            @(negedge clk);
            check("stall_taps_hold", {z1, z2, z3, z4, z5, z6}, 48'h00_01_02_20_21_22);
            check("stall_in_ready", {47'd0, in_ready}, 48'd0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
    endtask

    initial begin
        int w0;
        int f0;

        // Hand-computed windows for p(r,c)=16*r+c on 5x4: centres (1,1..3), (2,1..3).
        exp_a[0] = 48'h00_01_02_20_21_22;
        exp_a[1] = 48'h01_02_03_21_22_23;
        exp_a[2] = 48'h02_03_04_22_23_24;
        exp_a[3] = 48'h10_11_12_30_31_32;
        exp_a[4] = 48'h11_12_13_31_32_33;
        exp_a[5] = 48'h12_13_14_32_33_34;

        repeat (3) @(negedge clk);
        check("reset_out_valid", {47'd0, out_valid}, 48'd0);
        check("reset_in_ready", {47'd0, in_ready}, 48'd1);
        check("reset_frame_done", {47'd0, frame_done}, 48'd0);
        check("reset_taps", {z1, z2, z3, z4, z5, z6}, 48'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;

        // Single frame, sink always ready.
        w0 = win_seen; f0 = fd_cnt;
        fill_pattern(8'h00);
        push_table(8'h00);
        send_frame(1'b0);
        in_valid = 1'b0;
        drain("drain_basic");
        check("count_basic", 48'(win_seen - w0), 48'd6);
        check("frame_done_basic", 48'(fd_cnt - f0), 48'd1);

        // Downstream stall on the first window.
        w0 = win_seen;
        out_ready = 1'b0;
        push_table(8'h00);
        fork
            send_frame(1'b0);
            stall_ctrl();
        join
        in_valid = 1'b0;
        drain("drain_stall");
        check("count_stall", 48'(win_seen - w0), 48'd6);

        // Two frames back-to-back; second frame offset by 0x80.
        w0 = win_seen; f0 = fd_cnt;
        push_table(8'h00);
        push_table(8'h80);
        fill_pattern(8'h00);
        send_frame(1'b0);
        fill_pattern(8'h80);
        send_frame(1'b0);
        in_valid = 1'b0;
        drain("drain_b2b");
        check("count_b2b", 48'(win_seen - w0), 48'd12);
        check("frame_done_b2b", 48'(fd_cnt - f0), 48'd2);

        // Reset after 7 pixels, then a clean frame.
        fill_pattern(8'h00);
        for (int i = 0; i < 7; i++) send_pixel(fpix[i]);
        in_valid = 1'b0;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        w0 = win_seen; f0 = fd_cnt;
        push_table(8'h00);
        send_frame(1'b0);
        in_valid = 1'b0;
        drain("drain_reset");
        check("count_reset", 48'(win_seen - w0), 48'd6);
        check("frame_done_reset", 48'(fd_cnt - f0), 48'd1);

        // Random data with extreme values, random gaps and random backpressure.
        for (int f = 0; f < 3; f++) begin
            w0 = win_seen;
            for (int i = 0; i < NPIX; i++) fpix[i] = 8'($urandom_range(0, 255));
            fpix[0] = 8'h00;
            fpix[7] = 8'hFF;
            fpix[NPIX-1] = 8'hFF;
            push_model();
            rand_ready = 1'b1;
            send_frame(1'b1);
            in_valid = 1'b0;
            rand_ready = 1'b0;
            @(posedge clk);
            #3;
            out_ready = 1'b1;
            drain("drain_random");
            check("count_random", 48'(win_seen - w0), 48'd6);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
